// File: rtl/mem_pkg.sv
// Shared constants and types for the data-memory arbiter slice.
// lane_vec_t is the 16-lane vector, and mask_lanes reduces it to the 16 bits per lane that memory actually stores.
package mem_pkg;
  localparam int LANES   = 16;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 18;
  localparam int STORE_W = 16;

  typedef logic [LANES-1:0][DATA_W-1:0] lane_vec_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} memarb_state_t;

  // Upper lane bits are never stored. A scalar access only carries lane 0.
  function automatic lane_vec_t mask_lanes(input lane_vec_t d, input logic scalar_only);
    lane_vec_t r;
    for (int k = 0; k < LANES; k++) begin
      r[k] = {{(DATA_W-STORE_W){1'b0}}, d[k][STORE_W-1:0]};
      if (scalar_only && k != 0) r[k] = '0;
    end
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. It produces a one-hot grant by searching upward from ptr+1 and wrapping.
// The pointer moves to the winner only when the grant is actually accepted.
module rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             accept,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] grant_idx
);
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] cand;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = PTR_W'((int'(ptr) + off) % N_REQ);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= PTR_W'(N_REQ - 1);
    else if (accept) ptr <= grant_idx;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one mem_control port between N_REQ requesters and runs one transaction at a time.
// The transaction moves IDLE -> ISSUE -> WAIT(xRD_LAT, reads only) -> RESP; an out-of-range request goes straight to RESP.
module mem_arbiter #(
  parameter int N_REQ     = 2,
  parameter int LANES     = 16,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 18,
  parameter int MEM_DEPTH = 262144,
  parameter int RD_LAT    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req_valid,
  input  logic [N_REQ-1:0]                req_we,
  input  logic [N_REQ-1:0]                req_vec,
  input  logic [N_REQ*ADDR_W-1:0]         req_addr,
  input  logic [N_REQ*LANES*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]                req_ready,
  output logic [N_REQ-1:0]                rsp_valid,
  output logic                            rsp_err,
  output logic [LANES*DATA_W-1:0]         rsp_rdata,
  output logic                            busy,
  output logic [ADDR_W-1:0]               mem_address,
  output logic [LANES*DATA_W-1:0]         mem_data,
  output logic                            mem_wren,
  output logic                            mem_vec_scalar,
  input  logic [LANES*DATA_W-1:0]         mem_q
);
  import mem_pkg::*;

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int VEC_W = LANES * DATA_W;
  // Range limits are kept one bit wider than the address so MEM_DEPTH itself fits without wrapping.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W:0] VEC_LIM = (ADDR_W+1)'(MEM_DEPTH - LANES);

  memarb_state_t    state;
  logic [N_REQ-1:0] grant;
  logic [PTR_W-1:0] grant_idx;
  logic             accept;
  logic [PTR_W-1:0] owner;
  logic             cur_we;
  logic             cur_vec;
  logic [7:0]       wait_cnt;

  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W:0]   sel_addr_x;
  logic              sel_we;
  logic              sel_vec;
  logic              sel_err;
  lane_vec_t         sel_wdata;
  lane_vec_t         q_lanes;
  logic [N_REQ-1:0]  owner_oh;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready  = (state == IDLE) ? grant : '0;
  assign accept     = |(req_valid & req_ready);
  assign busy       = (state != IDLE);
  assign sel_addr   = req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign sel_addr_x = {1'b0, sel_addr};
  assign sel_we     = req_we[grant_idx];
  assign sel_vec    = req_vec[grant_idx];
  assign sel_wdata  = req_wdata[grant_idx*VEC_W +: VEC_W];
  assign sel_err    = (sel_addr_x >= DEPTH_X) || (sel_vec && sel_addr_x > VEC_LIM);
  assign q_lanes    = mem_q;
  assign owner_oh   = N_REQ'(1) << owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      owner          <= '0;
      cur_we         <= 1'b0;
      cur_vec        <= 1'b0;
      wait_cnt       <= '0;
      rsp_valid      <= '0;
      rsp_err        <= 1'b0;
      rsp_rdata      <= '0;
      mem_address    <= '0;
      mem_data       <= '0;
      mem_wren       <= 1'b0;
      mem_vec_scalar <= 1'b0;
    end else begin
      rsp_valid <= '0;
      mem_wren  <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          owner   <= grant_idx;
          cur_we  <= sel_we;
          cur_vec <= sel_vec;
          if (sel_err) begin
            state     <= RESP;
            rsp_valid <= grant;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            state          <= ISSUE;
            mem_address    <= sel_addr;
            mem_vec_scalar <= sel_vec;
            mem_data       <= mask_lanes(sel_wdata, 1'b0);
            mem_wren       <= sel_we;
          end
        end
        ISSUE: if (cur_we) begin
          state     <= RESP;
          rsp_valid <= owner_oh;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end else begin
          state    <= WAIT;
          wait_cnt <= 8'(RD_LAT - 1);
        end
        WAIT: if (wait_cnt == 8'd0) begin
          state     <= RESP;
          rsp_valid <= owner_oh;
          rsp_err   <= 1'b0;
          rsp_rdata <= mask_lanes(q_lanes, !cur_vec);
        end else begin
          wait_cnt <= wait_cnt - 8'd1;
        end
        RESP: begin
          state   <= IDLE;
          rsp_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural mem_control, directed cases, and a short random phase.
// Responses are checked against an expected queue that is filled at handshake time.
module tb_mem_arbiter;
  localparam int N = 2;
  localparam int AW = 18;
  localparam int VW = 512;
  localparam int EW = N + 1 + VW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_we = '0;
  logic [N-1:0]      req_vec = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*VW-1:0]   req_wdata = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic              rsp_err;
  logic [VW-1:0]     rsp_rdata;
  logic              busy;
  logic [AW-1:0]     mem_address;
  logic [VW-1:0]     mem_data;
  logic              mem_wren;
  logic              mem_vec_scalar;
  logic [VW-1:0]     mem_q = '0;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_vec(req_vec),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_vec_scalar(mem_vec_scalar), .mem_q(mem_q)
  );

  // clock/reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // behavioural mem_control, one-cycle read latency; garbage in the upper half of each lane
  logic [15:0] mem_model[int];
  always @(posedge clk) begin
    logic [VW-1:0] q;
    int a;
    q = '0;
    if (mem_wren)
      for (int k = 0; k < 16; k++)
        if (mem_vec_scalar || k == 0) mem_model[int'(mem_address) + k] = mem_data[k*32 +: 16];
    for (int k = 0; k < 16; k++) begin
      a = int'(mem_address) + k;
      q[k*32 +: 32] = {16'hA5A5, mem_model.exists(a) ? mem_model[a] : 16'h0000};
    end
    mem_q <= q;
  end

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [15:0]   ref_mem[int];

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_txn(input int r, input bit we, input bit vec, input logic [AW-1:0] addr,
                            input logic [VW-1:0] wd);
    int a;
    bit err;
    logic [VW-1:0] rd;
    logic [N-1:0] oh;
    a   = int'(addr);
    err = (vec && a > 262144 - 16) || a >= 262144;
    rd  = '0;
    oh  = N'(1) << r;
    if (!err) begin
      for (int k = 0; k < 16; k++) begin
        if (vec || k == 0) begin
          if (we) ref_mem[a + k] = wd[k*32 +: 16];
          else rd[k*32 +: 16] = ref_mem.exists(a + k) ? ref_mem[a + k] : 16'h0000;
        end
      end
    end
    exp_q.push_back({oh, err, rd});
  endtask

  int rsp_cnt = 0, rsp_cyc = 0, wren_cnt = 0, wren_cyc = 0;
  logic wren_vec;
  logic [31:0] wren_lane0;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (mem_wren) begin
      wren_cnt++;
      wren_cyc   = cyc;
      wren_vec   = mem_vec_scalar;
      wren_lane0 = mem_data[31:0];
    end
    if (|rsp_valid) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      if (exp_q.size() == 0) check("rsp_unexpected", VW'(rsp_valid), '0);
      else begin
        e = exp_q.pop_front();
        check("rsp_owner", VW'(rsp_valid), VW'(e[EW-1 -: N]));
        check("rsp_err", VW'(rsp_err), VW'(e[VW]));
        check("rsp_rdata", rsp_rdata, e[VW-1:0]);
      end
    end
  end

  // driver tasks
  task automatic send(input int r, input bit we, input bit vec, input logic [AW-1:0] addr,
                      input logic [VW-1:0] wd, output int t);
    req_we[r] = we;
    req_vec[r] = vec;
    req_addr[r*AW +: AW] = addr;
    req_wdata[r*VW +: VW] = wd;
    req_valid[r] = 1'b1;
    t = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("hs_timeout", '0, VW'(1));
    else expect_txn(r, we, vec, addr, wd);
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(input int n0);
    for (int i = 0; i < 40 && rsp_cnt <= n0; i++) begin
      @(negedge clk);
      #1;
    end
    check("rsp_timeout", VW'(rsp_cnt > n0), VW'(1));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("drain", VW'(exp_q.size()), '0);
  endtask

  task automatic first_grant_check(input string tag);
    req_valid = '1;
    @(negedge clk);
    check(tag, VW'(req_ready), VW'(2'b01));
    #1 req_valid = '0;
  endtask

  initial begin
    int t, rc0, wc0, n, o, r;
    logic [VW-1:0] wd;
    logic [AW-1:0] a;
    bit we, vec;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", VW'(busy), '0);
    check("rst_rsp_valid", VW'(rsp_valid), '0);
    check("rst_wren", VW'(mem_wren), '0);
    check("rst_addr", VW'(mem_address), '0);
    @(posedge clk);
    #1 rst = 1'b0;
    first_grant_check("first_grant");
    @(posedge clk);
    #1;

    // 1: vector write r0
    for (int k = 0; k < 16; k++) wd[k*32 +: 32] = 32'h10 + k;
    rc0 = rsp_cnt; wc0 = wren_cnt;
    send(0, 1, 1, 18'h00100, wd, t);
    wait_rsp(rc0);
    check("t1_wren_lat", VW'(wren_cyc - t), VW'(1));
    check("t1_wren_cnt", VW'(wren_cnt - wc0), VW'(1));
    check("t1_wren_vec", VW'(wren_vec), VW'(1));
    check("t1_rsp_lat", VW'(rsp_cyc - t), VW'(2));

    // 2: vector read r1
    rc0 = rsp_cnt;
    send(1, 0, 1, 18'h00100, '0, t);
    wait_rsp(rc0);
    check("t2_rsp_lat", VW'(rsp_cyc - t), VW'(3));
    check("t2_lane5", VW'(rsp_rdata[5*32 +: 32]), VW'(32'h15));

    // 3: scalar write over a vector-filled region, then scalar read
    for (int k = 0; k < 16; k++) wd[k*32 +: 32] = 32'h1230 + k;
    send(0, 1, 1, 18'h00200, wd, t);
    wait_drain();
    wd = '0;
    wd[31:0] = 32'hDEAD_BEEF;
    rc0 = rsp_cnt;
    send(0, 1, 0, 18'h00200, wd, t);
    wait_rsp(rc0);
    check("t3_wren_vec", VW'(wren_vec), '0);
    check("t3_wdata_mask", VW'(wren_lane0), VW'(32'h0000BEEF));
    rc0 = rsp_cnt;
    send(1, 0, 0, 18'h00200, '0, t);
    wait_rsp(rc0);
    check("t3_scalar_rd", rsp_rdata, VW'(32'h0000BEEF));

    // 4: both requesters held, alternating grants
    req_we = '0;
    req_vec = 2'b01;
    req_addr = {18'h00200, 18'h00100};
    req_valid = 2'b11;
    n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      check("t4_ready_onehot", VW'($countones(req_ready) <= 1), VW'(1));
      if (|req_ready) begin
        o = req_ready[1] ? 1 : 0;
        check("t4_rr_grant", VW'(o), VW'(n % 2));
        expect_txn(o, 1'b0, req_vec[o], req_addr[o*AW +: AW], '0);
        n++;
        if (n == 4) begin
          @(posedge clk);
          #1 req_valid = '0;
        end
      end
    end
    check("t4_grants", VW'(n), VW'(4));
    req_valid = '0;
    wait_drain();

    // 5: range boundary
    rc0 = rsp_cnt; wc0 = wren_cnt;
    send(0, 0, 1, 18'h3FFF1, '0, t);
    wait_rsp(rc0);
    check("t5_err_lat", VW'(rsp_cyc - t), VW'(1));
    check("t5_no_wren", VW'(wren_cnt - wc0), '0);
    rc0 = rsp_cnt;
    send(1, 0, 1, 18'h3FFF0, '0, t);
    wait_rsp(rc0);
    check("t5_ok_lat", VW'(rsp_cyc - t), VW'(3));

    // random phase
    for (int i = 0; i < 12; i++) begin
      r   = $urandom_range(0, 1);
      we  = 1'($urandom_range(0, 1));
      vec = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 3) == 0) ? AW'(18'h3FFF0 + $urandom_range(0, 15))
                                        : AW'(18'h00300 + $urandom_range(0, 31));
      for (int k = 0; k < 16; k++) wd[k*32 +: 32] = $urandom;
      send(r, we, vec, a, wd, t);
      wait_drain();
    end

    // 6: reset during WAIT
    send(0, 0, 1, 18'h00100, '0, t);
    @(posedge clk);
    #1;
    check("t6_busy_wait", VW'(busy), VW'(1));
    rst = 1'b1;
    exp_q.delete();
    rc0 = rsp_cnt;
    @(posedge clk);
    @(negedge clk);
    check("t6_busy", VW'(busy), '0);
    check("t6_rsp_valid", VW'(rsp_valid), '0);
    check("t6_rdata", rsp_rdata, '0);
    check("t6_wren", VW'(mem_wren), '0);
    check("t6_addr", VW'(mem_address), '0);
    check("t6_vec", VW'(mem_vec_scalar), '0);
    check("t6_mdata", mem_data, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    check("t6_no_rsp", VW'(rsp_cnt - rc0), '0);
    #1;
    first_grant_check("t6_first_grant");
    @(posedge clk);
    #1;
    send(0, 0, 1, 18'h00100, '0, t);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
